// File: rtl/imem_loader_if.sv
// Bus bundle between the UART byte source, the loader and the instruction
// RAM write port / CPU control. The loader uses the slave view; whatever feeds
// bytes and observes the writes uses the master view.
interface imem_loader_if #(
  parameter int ADDR_W = 8
) ();
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              error;

  modport slave (
    input  rx_data, rx_valid,
    output mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, error
  );

  modport master (
    output rx_data, rx_valid,
    input  mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, error
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: serial program loader for the CPU instruction memory.
// Frame: 0xA5, NHI, NLO, 4*N payload bytes (big-endian words), CSUM, where
// CSUM is the 8-bit wrapping sum of the payload bytes. Words are written to
// the instruction RAM from word 0 upward; the CPU is held in reset while a
// frame is in progress and released only after a matching checksum.
// Optional feature: define IMEM_LOADER_TIMEOUT_EN to abort a frame that sees
// TIMEOUT_CYC consecutive cycles without a byte.
module imem_loader #(
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 256,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic          clk,
  input  logic          rst_n,
  imem_loader_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, CNT_HI, CNT_LO, DATA, CSUM, ERR} state_t;

  localparam logic [7:0]  SYNC    = 8'hA5;
  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  state_t            state;
  logic [7:0]        cnt_hi;
  logic [15:0]       n_words;
  logic [15:0]       word_idx;
  logic [1:0]        byte_cnt;
  logic [7:0]        sum;
  logic [23:0]       shreg;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              error;

  logic [15:0]       n_rx;
  logic [31:0]       word_rx;

  // Wrapping 8-bit checksum accumulation.
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  assign n_rx    = {cnt_hi, bus.rx_data};
  assign word_rx = {shreg, bus.rx_data};

`ifdef IMEM_LOADER_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC - 1);
  logic [31:0] to_cnt;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC > 0);
`endif

  // Frame parser, word assembler and write strobe generation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt_hi    <= '0;
      n_words   <= '0;
      word_idx  <= '0;
      byte_cnt  <= '0;
      sum       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_hold  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
`ifdef IMEM_LOADER_TIMEOUT_EN
      to_cnt    <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      case (state)
        // ERR keeps cpu_hold high; only a sync byte restarts loading.
        IDLE, ERR: begin
          if (bus.rx_valid && bus.rx_data == SYNC) begin
            state    <= CNT_HI;
            busy     <= 1'b1;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
            sum      <= '0;
            word_idx <= '0;
            byte_cnt <= '0;
          end
        end
        CNT_HI: begin
          if (bus.rx_valid) begin
            cnt_hi <= bus.rx_data;
            state  <= CNT_LO;
          end
        end
        CNT_LO: begin
          if (bus.rx_valid) begin
            n_words <= n_rx;
            if ({1'b0, n_rx} > DEPTH_L) begin
              state <= ERR;
              error <= 1'b1;
              busy  <= 1'b0;
            end else if (n_rx == 16'd0) begin
              state <= CSUM;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (bus.rx_valid) begin
            shreg    <= word_rx[23:0];
            sum      <= csum_add(sum, bus.rx_data);
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              mem_we    <= 1'b1;
              mem_addr  <= word_idx[ADDR_W-1:0];
              mem_wdata <= word_rx;
              word_idx  <= word_idx + 16'd1;
              if (word_idx == n_words - 16'd1) begin
                state <= CSUM;
              end
            end
          end
        end
        CSUM: begin
          if (bus.rx_valid) begin
            busy <= 1'b0;
            if (bus.rx_data == sum) begin
              state    <= IDLE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase

`ifdef IMEM_LOADER_TIMEOUT_EN
      // Inter-byte watchdog: overrides the case above when it expires.
      if (state inside {CNT_HI, CNT_LO, DATA, CSUM}) begin
        if (bus.rx_valid) begin
          to_cnt <= '0;
        end else if (to_cnt == TO_LAST) begin
          to_cnt <= '0;
          state  <= ERR;
          error  <= 1'b1;
          busy   <= 1'b0;
        end else begin
          to_cnt <= to_cnt + 32'd1;
        end
      end else begin
        to_cnt <= '0;
      end
`endif
    end
  end

  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.cpu_hold  = cpu_hold;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.error     = error;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: directed frames, a frame-level reference model
// that derives expected writes and final flags from the byte stream, and a
// per-cycle compare process on the RAM write port.
module tb_imem_loader;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;
  localparam int TO     = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int idx; logic [ADDR_W-1:0] addr; logic [31:0] data; } trig_t;
  typedef struct { int cyc; logic [ADDR_W-1:0] addr; logic [31:0] data; } wr_t;

  logic [7:0]        stim[$];
  trig_t             trig[$];
  wr_t               expq[$];
  logic [ADDR_W-1:0] act_addr[$];
  logic [31:0]       act_data[$];
  logic [ADDR_W-1:0] last_addr;
  logic [31:0]       last_data;
  bit                chk_en = 1'b0;
  bit m_busy = 1'b0, m_hold = 1'b0, m_done = 1'b0, m_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-level model: expected writes (keyed by stream byte index) and flags.
  task automatic model_frame();
    int s;
    int n;
    int base;
    logic [7:0] sum;
    s = -1;
    sum = 8'h00;
    trig.delete();
    foreach (stim[i]) if (s < 0 && stim[i] == 8'hA5) s = i;
    if (s < 0) return;
    m_busy = 1'b1; m_hold = 1'b1; m_done = 1'b0; m_err = 1'b0;
    if (stim.size() < s + 3) return;
    n = int'({stim[s+1], stim[s+2]});
    if (n > DEPTH) begin
      m_busy = 1'b0; m_err = 1'b1;
      return;
    end
    for (int k = 0; k < n; k++) begin
      base = s + 3 + 4 * k;
      if (base + 3 >= stim.size()) return;
      trig.push_back('{base + 3, ADDR_W'(k),
                       {stim[base], stim[base+1], stim[base+2], stim[base+3]}});
      sum = sum + stim[base] + stim[base+1] + stim[base+2] + stim[base+3];
    end
    if (s + 3 + 4 * n >= stim.size()) return;
    m_busy = 1'b0;
    if (stim[s + 3 + 4 * n] == sum) begin
      m_done = 1'b1; m_hold = 1'b0;
    end else begin
      m_err = 1'b1;
    end
  endtask

  // Write-port check every cycle: strobe timing, address/data, and hold.
  always @(negedge clk) begin
    bit exp_we;
    if (chk_en) begin
      exp_we = (expq.size() > 0 && expq[0].cyc == cyc);
      check("mem_we", 32'(bus.mem_we), 32'(exp_we));
      if (exp_we) begin
        last_addr = expq[0].addr;
        last_data = expq[0].data;
        void'(expq.pop_front());
      end
      if (bus.mem_we) begin
        act_addr.push_back(bus.mem_addr);
        act_data.push_back(bus.mem_wdata);
      end
      check("mem_addr", 32'(bus.mem_addr), 32'(last_addr));
      check("mem_wdata", bus.mem_wdata, last_data);
    end
  end

  task automatic drive(input int gap, input int stall_at, input int stall_len);
    int t;
    int idle;
    t = 0;
    model_frame();
    act_addr.delete();
    act_data.delete();
    for (int i = 0; i < stim.size(); i++) begin
      @(negedge clk);
      bus.rx_data  = stim[i];
      bus.rx_valid = 1'b1;
      if (t < trig.size() && trig[t].idx == i) begin
        expq.push_back('{cyc + 1, trig[t].addr, trig[t].data});
        t++;
      end
      idle = gap + ((i == stall_at) ? stall_len : 0);
      for (int g = 0; g < idle; g++) begin
        @(negedge clk);
        bus.rx_valid = 1'b0;
      end
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_done"},  32'(bus.done),     32'(m_done));
    check({tag, "_error"}, 32'(bus.error),    32'(m_err));
    check({tag, "_busy"},  32'(bus.busy),     32'(m_busy));
    check({tag, "_hold"},  32'(bus.cpu_hold), 32'(m_hold));
    check({tag, "_pending_writes"}, 32'(expq.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"},    32'(bus.mem_we),   32'd0);
    check({tag, "_addr"},  32'(bus.mem_addr), 32'd0);
    check({tag, "_wdata"}, bus.mem_wdata,     32'd0);
    check({tag, "_hold"},  32'(bus.cpu_hold), 32'd0);
    check({tag, "_busy"},  32'(bus.busy),     32'd0);
    check({tag, "_done"},  32'(bus.done),     32'd0);
    check({tag, "_error"}, 32'(bus.error),    32'd0);
  endtask

  initial begin
    #2000000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    last_addr = '0;
    last_data = '0;
    chk_en = 1'b1;
    rst_n = 1'b1;

    // 1) Two words back-to-back; checksum 0x43 = low byte of the payload sum.
    stim = '{8'hA5, 8'h00, 8'h02, 8'h3C, 8'h08, 8'h40, 8'h09,
             8'hAD, 8'h09, 8'h00, 8'h00, 8'h43};
    drive(0, -1, 0);
    check_flags("t1");
    check("t1_nwrites", 32'(act_data.size()), 32'd2);
    check("t1_addr0", 32'(act_addr[0]), 32'd0);
    check("t1_data0", act_data[0], 32'h3C084009);
    check("t1_addr1", 32'(act_addr[1]), 32'd1);
    check("t1_data1", act_data[1], 32'hAD090000);
    check("t1_done_lit", 32'(bus.done), 32'd1);
    check("t1_hold_lit", 32'(bus.cpu_hold), 32'd0);

    // 2) Same frame, bad checksum: writes stay, error sticks, CPU held.
    stim = '{8'hA5, 8'h00, 8'h02, 8'h3C, 8'h08, 8'h40, 8'h09,
             8'hAD, 8'h09, 8'h00, 8'h00, 8'h00};
    drive(1, -1, 0);
    check_flags("t2");
    check("t2_nwrites", 32'(act_data.size()), 32'd2);
    check("t2_error_lit", 32'(bus.error), 32'd1);
    check("t2_hold_lit", 32'(bus.cpu_hold), 32'd1);
    check("t2_done_lit", 32'(bus.done), 32'd0);

    // 3a) Empty image, started from the error state.
    stim = '{8'hA5, 8'h00, 8'h00, 8'h00};
    drive(2, -1, 0);
    check_flags("t3a");
    check("t3a_nwrites", 32'(act_data.size()), 32'd0);
    check("t3a_done_lit", 32'(bus.done), 32'd1);

    // 3b) N = 257 exceeds the RAM depth.
    stim = '{8'hA5, 8'h01, 8'h01};
    drive(0, -1, 0);
    check_flags("t3b");
    check("t3b_nwrites", 32'(act_data.size()), 32'd0);
    check("t3b_error_lit", 32'(bus.error), 32'd1);

    // 4) Leading junk ignored; 0xA5 in payload is plain data. CSUM 0x0B.
    stim = '{8'h12, 8'h34, 8'hA5, 8'h00, 8'h01, 8'hA5, 8'h11, 8'h22, 8'h33, 8'h0B};
    drive(0, -1, 0);
    check_flags("t4");
    check("t4_nwrites", 32'(act_data.size()), 32'd1);
    check("t4_data0", act_data[0], 32'hA5112233);
    check("t4_done_lit", 32'(bus.done), 32'd1);

    // 5) Reset after 6 payload bytes of a 2-word frame.
    stim = '{8'hA5, 8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    drive(0, -1, 0);
    check_flags("t5_pre");
    check("t5_nwrites", 32'(act_data.size()), 32'd1);
    check("t5_data0", act_data[0], 32'h01020304);
    chk_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("t5_rst");
    rst_n = 1'b1;
    last_addr = '0;
    last_data = '0;
    m_busy = 1'b0; m_hold = 1'b0; m_done = 1'b0; m_err = 1'b0;
    chk_en = 1'b1;

    // 5b) Fresh frame after reset loads from address 0. CSUM 0x38.
    stim = '{8'hA5, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h38};
    drive(1, -1, 0);
    check_flags("t5b");
    check("t5b_nwrites", 32'(act_data.size()), 32'd1);
    check("t5b_addr0", 32'(act_addr[0]), 32'd0);
    check("t5b_data0", act_data[0], 32'hDEADBEEF);

`ifdef IMEM_LOADER_TIMEOUT_EN
    // 6a) 15 idle cycles mid-DATA: frame still completes. CSUM 0xAA.
    stim = '{8'hA5, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA};
    drive(0, 4, 15);
    check_flags("t6a");
    check("t6a_data0", act_data[0], 32'h11223344);

    // 6b) 16 idle cycles mid-DATA: frame aborts, nothing written.
    stim = '{8'hA5, 8'h00, 8'h01, 8'h11, 8'h22};
    drive(0, 4, 16);
    check("t6b_error", 32'(bus.error), 32'd1);
    check("t6b_hold", 32'(bus.cpu_hold), 32'd1);
    check("t6b_busy", 32'(bus.busy), 32'd0);
    check("t6b_done", 32'(bus.done), 32'd0);
    check("t6b_nwrites", 32'(act_data.size()), 32'd0);
`endif

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
